// File: rtl/usb_evt_ctrl.sv
// USB core event controller: per-source pending latches, priority arbitration into a
// FIFO, sticky overflow, count/timeout interrupt coalescing and a 16-bit register window.
module usb_evt_ctrl #(
  parameter int unsigned N_SRC     = 2,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TMO_SHIFT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_SRC-1:0]      src_stb,
  input  logic [12*N_SRC-1:0]   src_data,
  input  logic [1:0]            wb_addr,
  input  logic [15:0]           wb_wdata,
  output logic [15:0]           wb_rdata,
  input  logic                  wb_we,
  input  logic                  wb_cyc,
  output logic                  wb_ack,
  output logic                  irq
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW       = (TMO_SHIFT > 0) ? TMO_SHIFT : 1;
  localparam logic [3:0]  SRC_MASK = 4'((1 << N_SRC) - 1);
  localparam logic [4:0]  DEPTH_C  = 5'(DEPTH);

  typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_e;

  bus_state_e        bus_q, bus_d;
  logic              irq_en_q;
  logic [3:0]        src_en_q;
  logic [4:0]        thr_q;
  logic [15:0]       tmo_q;
  logic              ovf_q, ovf_d;
  logic [N_SRC-1:0]  lat_v_q, lat_v_d;
  logic [11:0]       lat_d_q [N_SRC];
  logic [11:0]       lat_d_d [N_SRC];
  logic [13:0]       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [4:0]        count_q;
  logic [15:0]       timer_q, timer_d;
  logic [PW-1:0]     pre_q;
  logic              irq_q, irq_d;

  logic              acc, wr_acc, evt_rd, flush, pop, push, empty, full, tick;
  logic              found, ovf_set;
  logic [1:0]        sel;
  logic [11:0]       sel_data;
  logic [N_SRC-1:0]  drain;
  logic [13:0]       head;
  logic [4:0]        thr_eff;

  // Bus handshake: one ack per request, so a held cyc yields ack every other cycle
  always_comb begin
    bus_d = bus_q;
    case (bus_q)
      BUS_IDLE: if (wb_cyc) bus_d = BUS_ACK;
      BUS_ACK:  bus_d = BUS_IDLE;
      default:  bus_d = BUS_IDLE;
    endcase
  end

  assign acc    = (bus_q == BUS_ACK);
  assign wb_ack = acc;
  assign wr_acc = acc & wb_we;
  assign evt_rd = acc & ~wb_we & (wb_addr == 2'd2);
  assign flush  = wr_acc & (wb_addr == 2'd3) & wb_wdata[0];
  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_C);
  assign pop    = evt_rd & ~empty;
  assign tick   = (TMO_SHIFT == 0) ? 1'b1 : (&pre_q);

  // Lowest-index pending latch wins; push is gated by full only
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (lat_v_q[i] && !found) begin
        found    = 1'b1;
        sel      = 2'(i);
        sel_data = lat_d_q[i];
      end
    end
    push  = found & ~full;
    drain = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      drain[i] = push && (sel == 2'(i));
    end
  end

  // A strobe reloads a latch that drains this cycle; otherwise a busy latch drops it
  always_comb begin
    lat_v_d = lat_v_q;
    lat_d_d = lat_d_q;
    ovf_set = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (src_stb[i] && src_en_q[i]) begin
        if (lat_v_q[i] && !drain[i]) begin
          ovf_set = 1'b1;
        end else begin
          lat_v_d[i] = 1'b1;
          lat_d_d[i] = src_data[12*i +: 12];
        end
      end else if (drain[i]) begin
        lat_v_d[i] = 1'b0;
      end
    end
    if (flush) lat_v_d = '0;
  end

  always_comb begin
    ovf_d   = (ovf_q & ~evt_rd) | ovf_set;
    timer_d = timer_q;
    if (empty || pop || flush) begin
      timer_d = '0;
    end else if (tick && (timer_q != '1)) begin
      timer_d = timer_q + 16'd1;
    end
    thr_eff = (thr_q == '0) ? 5'd1 : thr_q;
    irq_d   = irq_en_q & ((count_q >= thr_eff) |
                          ((tmo_q != '0) & ~empty & (timer_q >= tmo_q)));
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wb_rdata = '0;
    if (acc) begin
      case (wb_addr)
        2'd0:    wb_rdata = {irq_en_q, src_en_q, 6'b0, thr_q};
        2'd1:    wb_rdata = tmo_q;
        2'd2:    wb_rdata = {~empty, ovf_q, head};
        default: wb_rdata = {irq_q, ovf_q, 1'b0, count_q, 8'h00};
      endcase
    end
  end

  assign irq = irq_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {sel, sel_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q    <= BUS_IDLE;
      irq_en_q <= 1'b0;
      src_en_q <= '0;
      thr_q    <= '0;
      tmo_q    <= '0;
      ovf_q    <= 1'b0;
      lat_v_q  <= '0;
      for (int unsigned i = 0; i < N_SRC; i++) lat_d_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      pre_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      bus_q   <= bus_d;
      ovf_q   <= ovf_d;
      lat_v_q <= lat_v_d;
      lat_d_q <= lat_d_d;
      timer_q <= timer_d;
      pre_q   <= pre_q + PW'(1);
      irq_q   <= irq_d;
      if (wr_acc && (wb_addr == 2'd0)) begin
        irq_en_q <= wb_wdata[15];
        src_en_q <= wb_wdata[14:11] & SRC_MASK;
        thr_q    <= wb_wdata[4:0];
      end
      if (wr_acc && (wb_addr == 2'd1)) tmo_q <= wb_wdata;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        if (push && !pop)      count_q <= count_q + 5'd1;
        else if (pop && !push) count_q <= count_q - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_usb_evt_ctrl.sv
// Scoreboarded bench for usb_evt_ctrl: two instances (4 sources/8 deep/no prescale and
// 2 sources/2 deep) share the bus address/data lines with separate cycle requests.
module tb_usb_evt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic        we;

  logic [3:0]  stb_a;
  logic [47:0] data_a;
  logic [15:0] rdata_a;
  logic        cyc_a, ack_a, irq_a;

  logic [1:0]  stb_b;
  logic [23:0] data_b;
  logic [15:0] rdata_b;
  logic        cyc_b, ack_b, irq_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [15:0] exp;
    bit          chk;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  usb_evt_ctrl #(.N_SRC(4), .DEPTH(8), .TMO_SHIFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .src_stb(stb_a), .src_data(data_a),
    .wb_addr(addr), .wb_wdata(wdata), .wb_rdata(rdata_a), .wb_we(we),
    .wb_cyc(cyc_a), .wb_ack(ack_a), .irq(irq_a)
  );

  usb_evt_ctrl #(.N_SRC(2), .DEPTH(2), .TMO_SHIFT(4)) u_b (
    .clk(clk), .rst_n(rst_n), .src_stb(stb_b), .src_data(data_b),
    .wb_addr(addr), .wb_wdata(wdata), .wb_rdata(rdata_b), .wb_we(we),
    .wb_cyc(cyc_b), .wb_ack(ack_b), .irq(irq_b)
  );

  // Monitor: every ack pops the matching expectation
  always @(negedge clk) begin
    if (ack_a) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_ack_a: rdata=%h with no expectation", rdata_a);
      end else begin
        ea = q_a.pop_front();
        if (ea.chk) begin
          n_tests++;
          if (rdata_a !== ea.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", ea.name, rdata_a, ea.exp);
          end
        end
      end
    end
    if (ack_b) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_ack_b: rdata=%h with no expectation", rdata_b);
      end else begin
        eb = q_b.pop_front();
        if (eb.chk) begin
          n_tests++;
          if (rdata_b !== eb.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", eb.name, rdata_b, eb.exp);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic bus(input bit b, input logic [1:0] a, input bit w, input logic [15:0] d,
                     input logic [15:0] exp, input string nm);
    exp_t e;
    bit   got;
    e.name = nm;
    e.exp  = exp;
    e.chk  = !w;
    if (b) q_b.push_back(e);
    else   q_a.push_back(e);
    addr  = a;
    we    = w;
    wdata = d;
    if (b) cyc_b = 1'b1;
    else   cyc_a = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = b ? ack_b : ack_a;
      @(posedge clk); #1;
    end
    cyc_a = 1'b0;
    cyc_b = 1'b0;
    we    = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s: bus timeout, ack 0 expected 1", nm);
    end
  endtask

  task automatic wr(input bit b, input logic [1:0] a, input logic [15:0] d);
    bus(b, a, 1'b1, d, 16'h0000, "write");
  endtask

  task automatic rd(input bit b, input logic [1:0] a, input logic [15:0] exp, input string nm);
    bus(b, a, 1'b0, 16'h0000, exp, nm);
  endtask

  task automatic pulse_a(input logic [3:0] m, input logic [47:0] d);
    stb_a  = m;
    data_a = d;
    @(posedge clk); #1;
    stb_a  = '0;
  endtask

  task automatic pulse_b(input logic [1:0] m, input logic [23:0] d);
    stb_b  = m;
    data_b = d;
    @(posedge clk); #1;
    stb_b  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    addr = '0; wdata = '0; we = 1'b0;
    stb_a = '0; data_a = '0; cyc_a = 1'b0;
    stb_b = '0; data_b = '0; cyc_b = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Reset state
    chk("rst_irq_a", irq_a, 0);
    chk("rst_irq_b", irq_b, 0);
    chk("rst_ack_a", ack_a, 0);
    chk("rst_rdata_a", rdata_a, 16'h0000);
    rd(0, 2'd0, 16'h0000, "rst_ctrl_a");
    rd(0, 2'd3, 16'h0000, "rst_stat_a");

    // Single event: irq three edges after the strobe is driven
    wr(0, 2'd0, 16'hF801);
    pulse_a(4'b0001, 48'h000_000_000_123);
    chk("single_irq_e1", irq_a, 0);
    idle(1);
    chk("single_irq_e2", irq_a, 0);
    idle(1);
    chk("single_irq_e3", irq_a, 1);
    rd(0, 2'd2, 16'h8123, "single_evt");
    rd(0, 2'd3, 16'h0000, "single_stat");
    chk("single_irq_after", irq_a, 0);

    // Simultaneous strobes on src3 and src1 drain in ascending order
    pulse_a(4'b1010, 48'hABC_000_456_000);
    idle(3);
    rd(0, 2'd2, 16'h9456, "simul_src1");
    rd(0, 2'd2, 16'hBABC, "simul_src3");
    rd(0, 2'd2, 16'h0000, "simul_empty");
    rd(0, 2'd0, 16'hF801, "ctrl_readback_a");

    // Overflow on a pending latch collision, 2-deep FIFO
    wr(1, 2'd0, 16'hF801);
    rd(1, 2'd0, 16'h9801, "ctrl_srcen_mask_b");
    pulse_b(2'b01, 24'h000_001); idle(2);
    pulse_b(2'b01, 24'h000_002); idle(2);
    pulse_b(2'b01, 24'h000_003); idle(1);
    pulse_b(2'b01, 24'h000_004); idle(1);
    rd(1, 2'd3, 16'hC200, "ovf_stat");
    rd(1, 2'd2, 16'hC001, "ovf_evt1");
    rd(1, 2'd2, 16'h8002, "ovf_evt2");
    rd(1, 2'd2, 16'h8003, "ovf_evt3");
    rd(1, 2'd2, 16'h0000, "ovf_cleared");

    // Coalescing by timeout: thr=4, TMO=3, one event
    wr(0, 2'd0, 16'h8804);
    wr(0, 2'd1, 16'h0003);
    pulse_a(4'b0001, 48'h000_000_000_055);
    chk("tmo_irq_e1", irq_a, 0);
    for (int k = 2; k <= 6; k++) begin
      idle(1);
      chk($sformatf("tmo_irq_e%0d", k), irq_a, (k == 6) ? 16'd1 : 16'd0);
    end
    rd(0, 2'd2, 16'h8055, "tmo_evt");

    // Coalescing by count: TMO disabled, four events
    wr(0, 2'd1, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      pulse_a(4'b0001, 48'(k + 1));
      idle(1);
    end
    chk("cnt_irq_pre", irq_a, 0);
    idle(1);
    chk("cnt_irq_post", irq_a, 1);

    // Flush with events pending
    wr(0, 2'd3, 16'h0001);
    rd(0, 2'd3, 16'h0000, "flush_stat");
    chk("flush_irq", irq_a, 0);
    rd(0, 2'd2, 16'h0000, "flush_evt");

    // Asynchronous reset mid-burst during an ack
    for (int k = 0; k < 4; k++) begin
      pulse_a(4'b0001, 48'(k + 16'h100));
      idle(1);
    end
    idle(2);
    chk("pre_rst_irq", irq_a, 1);
    addr = 2'd0; we = 1'b0; cyc_a = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_ack", ack_a, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_irq", irq_a, 0);
    chk("rst_async_ack", ack_a, 0);
    chk("rst_async_rdata", rdata_a, 16'h0000);
    cyc_a = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    rd(0, 2'd0, 16'h0000, "post_rst_ctrl_a");
    rd(0, 2'd3, 16'h0000, "post_rst_stat_a");
    rd(1, 2'd0, 16'h0000, "post_rst_ctrl_b");

    idle(2);
    chk("sb_drained", 16'(q_a.size() + q_b.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
